hazard_ctrl: RTL and testbench

- Pipeline interlock and flush controller for the 5-stage 32-bit core.
- Covers the hazards that operand forwarding cannot resolve: load-use, the multi-cycle mult/div handshake, and taken-control-flow flushes.
- Drives PC, F/D, D/X and X/M latch enables and bubble inserts, and keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline interlock and flush controller: load-use stalls, mult/div issue/hold/release,
// taken-branch flushes, plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [31:0]      i_fd_ir,
    input  logic [31:0]      i_dx_ir,
    input  logic             i_ctrl_taken,
    input  logic             i_md_result_rdy,
    input  logic             i_md_exception,
    output logic             o_pc_en,
    output logic             o_fd_en,
    output logic             o_fd_flush,
    output logic             o_dx_en,
    output logic             o_dx_nop,
    output logic             o_xm_nop,
    output logic             o_ctrl_mult,
    output logic             o_ctrl_div,
    output logic             o_md_sel,
    output logic             o_md_exc,
    output logic             o_md_timeout,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int TW = $clog2(MD_TIMEOUT + 1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state;
    logic [TW-1:0]    r_tcnt;
    logic             r_md_timeout;
    logic [CNT_W-1:0] r_stall_count;

    logic [4:0] w_fd_op;
    logic [4:0] w_dx_op;
    logic [4:0] w_dx_rd;
    logic       w_dx_mul;
    logic       w_dx_div;
    logic [4:0] w_src_a;
    logic [4:0] w_src_b;
    logic       w_use_a;
    logic       w_use_b;
    logic       w_load_use;
    logic       w_timeout_hit;
    logic       w_release;
    logic       w_issue;
    logic       w_unused;

    assign w_fd_op  = i_fd_ir[31:27];
    assign w_dx_op  = i_dx_ir[31:27];
    assign w_dx_rd  = i_dx_ir[26:22];
    assign w_dx_mul = (w_dx_op == OP_RTYPE) && (i_dx_ir[6:2] == ALU_MUL);
    assign w_dx_div = (w_dx_op == OP_RTYPE) && (i_dx_ir[6:2] == ALU_DIV);
    assign w_unused = ^{i_fd_ir[11:0], i_dx_ir[21:7], i_dx_ir[1:0]};

    // Store data ([26:22] of sw) is deliberately not a source: W->M forwarding covers it.
    always_comb begin
        w_src_a = i_fd_ir[21:17];
        w_src_b = i_fd_ir[16:12];
        w_use_a = 1'b0;
        w_use_b = 1'b0;
        case (w_fd_op)
            OP_RTYPE: begin
                w_use_a = 1'b1;
                w_use_b = 1'b1;
            end
            OP_ADDI, OP_LW, OP_SW: w_use_a = 1'b1;
            OP_BNE, OP_BLT: begin
                w_src_a = i_fd_ir[26:22];
                w_src_b = i_fd_ir[21:17];
                w_use_a = 1'b1;
                w_use_b = 1'b1;
            end
            OP_JR: begin
                w_src_a = i_fd_ir[26:22];
                w_use_a = 1'b1;
            end
            OP_BEX: begin
                w_src_a = 5'd30;
                w_use_a = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0) &&
                        ((w_use_a && (w_src_a == w_dx_rd)) || (w_use_b && (w_src_b == w_dx_rd)));

    assign w_timeout_hit = (r_tcnt == TW'(MD_TIMEOUT - 1));
    assign w_release     = (r_state == BUSY) && (i_md_result_rdy || w_timeout_hit);
    assign w_issue       = (r_state == IDLE) && (w_dx_mul || w_dx_div) && !i_ctrl_taken;

    always_comb begin
        o_pc_en     = 1'b1;
        o_fd_en     = 1'b1;
        o_dx_en     = 1'b1;
        o_fd_flush  = 1'b0;
        o_dx_nop    = 1'b0;
        o_xm_nop    = 1'b0;
        o_ctrl_mult = 1'b0;
        o_ctrl_div  = 1'b0;
        o_md_sel    = 1'b0;
        o_md_exc    = 1'b0;
        if (!i_reset) begin
            o_fd_flush = 1'b1;
            o_dx_nop   = 1'b1;
            o_xm_nop   = 1'b1;
        end else if (r_state == BUSY) begin
            if (w_release) begin
                o_md_sel = 1'b1;
                o_md_exc = i_md_result_rdy ? i_md_exception : 1'b1;
            end else begin
                o_pc_en  = 1'b0;
                o_fd_en  = 1'b0;
                o_dx_en  = 1'b0;
                o_xm_nop = 1'b1;
            end
        end else if (i_ctrl_taken) begin
            o_fd_flush = 1'b1;
            o_dx_nop   = 1'b1;
        end else begin
            if (w_load_use) begin
                o_pc_en  = 1'b0;
                o_fd_en  = 1'b0;
                o_dx_nop = 1'b1;
            end
            o_ctrl_mult = w_dx_mul;
            o_ctrl_div  = w_dx_div;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_tcnt        <= '0;
            r_md_timeout  <= 1'b0;
            r_stall_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= BUSY;
                        r_tcnt  <= '0;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        if (!i_md_result_rdy) r_md_timeout <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (!o_pc_en && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign o_md_timeout  = r_md_timeout;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by a randomized
// phase, all checked against a cycle-level reference model of the interlock rules.
module tb_hazard_ctrl;

    localparam int MD_TIMEOUT = 64;
    localparam int CNT_W      = 8;
    localparam longint STALL_MAX = (64'd1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic [31:0]      fdIr;
    logic [31:0]      dxIr;
    logic             ctrlTaken;
    logic             mdRdy;
    logic             mdException;
    logic             pcEn, fdEn, fdFlush, dxEn, dxNop, xmNop;
    logic             ctrlMult, ctrlDiv, mdSel, mdExc, mdTimeout;
    logic [CNT_W-1:0] stallCount;

    int vectors = 0;
    int miscompares = 0;

    bit     mBusy = 0;
    int     mBusyCycles = 0;
    bit     mSticky = 0;
    longint mStall = 0;
    logic ePc, eFd, eFlush, eDx, eDxNop, eXmNop, eMult, eDiv, eSel, eExc;

    int multPulses = 0;
    int divPulses = 0;
    int cycleNo = 0;
    int lastDivCycle = 0;
    int divGap = 0;

    hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clock(clock), .i_reset(reset), .i_fd_ir(fdIr), .i_dx_ir(dxIr),
        .i_ctrl_taken(ctrlTaken), .i_md_result_rdy(mdRdy), .i_md_exception(mdException),
        .o_pc_en(pcEn), .o_fd_en(fdEn), .o_fd_flush(fdFlush), .o_dx_en(dxEn),
        .o_dx_nop(dxNop), .o_xm_nop(xmNop), .o_ctrl_mult(ctrlMult), .o_ctrl_div(ctrlDiv),
        .o_md_sel(mdSel), .o_md_exc(mdExc), .o_md_timeout(mdTimeout), .o_stall_count(stallCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rType(int rd, int rs, int rt, int alu);
        return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'b00000, 5'(alu), 2'b00};
    endfunction

    function automatic logic [31:0] iType(int op, int rd, int rs, int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    function automatic bit isMulDiv(logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
    endfunction

    // Does the F/D instruction need register r through an unforwardable path?
    function automatic bit readsReg(logic [31:0] ir, int r);
        int op = int'(ir[31:27]);
        int a  = int'(ir[26:22]);
        int s  = int'(ir[21:17]);
        int t  = int'(ir[16:12]);
        case (op)
            0:       return (r == s) || (r == t);
            5, 8, 7: return r == s;
            2, 6:    return (r == a) || (r == s);
            4:       return r == a;
            22:      return r == 30;
            default: return 0;
        endcase
    endfunction

    function automatic bit loadUse(logic [31:0] fd, logic [31:0] dx);
        int rd = int'(dx[26:22]);
        if (dx[31:27] != 5'd8 || rd == 0) return 0;
        return readsReg(fd, rd);
    endfunction

    task automatic checkOne(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycleNo, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("pc_en", 64'(pcEn), 64'(ePc));
        checkOne("fd_en", 64'(fdEn), 64'(eFd));
        checkOne("fd_flush", 64'(fdFlush), 64'(eFlush));
        checkOne("dx_en", 64'(dxEn), 64'(eDx));
        checkOne("dx_nop", 64'(dxNop), 64'(eDxNop));
        checkOne("xm_nop", 64'(xmNop), 64'(eXmNop));
        checkOne("ctrl_mult", 64'(ctrlMult), 64'(eMult));
        checkOne("ctrl_div", 64'(ctrlDiv), 64'(eDiv));
        checkOne("md_sel", 64'(mdSel), 64'(eSel));
        checkOne("md_exc", 64'(mdExc), 64'(eExc));
        checkOne("md_timeout", 64'(mdTimeout), 64'(mSticky));
        checkOne("stall_count", 64'(stallCount), 64'(mStall));
    endtask

    task automatic modelOutputs();
        ePc = 1; eFd = 1; eDx = 1; eFlush = 0; eDxNop = 0; eXmNop = 0;
        eMult = 0; eDiv = 0; eSel = 0; eExc = 0;
        if (!reset) begin
            eFlush = 1; eDxNop = 1; eXmNop = 1;
        end else if (mBusy) begin
            if (mdRdy || mBusyCycles == MD_TIMEOUT - 1) begin
                eSel = 1;
                eExc = mdRdy ? mdException : 1'b1;
            end else begin
                ePc = 0; eFd = 0; eDx = 0; eXmNop = 1;
            end
        end else if (ctrlTaken) begin
            eFlush = 1; eDxNop = 1;
        end else if (loadUse(fdIr, dxIr)) begin
            ePc = 0; eFd = 0; eDxNop = 1;
        end else if (isMulDiv(dxIr)) begin
            eMult = (dxIr[6:2] == 5'd6);
            eDiv  = (dxIr[6:2] == 5'd7);
        end
    endtask

    task automatic modelAdvance();
        if (!reset) begin
            mBusy = 0; mBusyCycles = 0; mSticky = 0; mStall = 0;
        end else begin
            if (!ePc && mStall < STALL_MAX) mStall++;
            if (mBusy) begin
                if (eSel) begin
                    mBusy = 0;
                    if (!mdRdy) mSticky = 1;
                end else begin
                    mBusyCycles++;
                end
            end else if (eMult || eDiv) begin
                mBusy = 1;
                mBusyCycles = 0;
            end
        end
    endtask

    task automatic applyStimulus(logic [31:0] fd, logic [31:0] dx, logic taken,
                                 logic rdy, logic exc, logic rst);
        fdIr = fd; dxIr = dx; ctrlTaken = taken; mdRdy = rdy; mdException = exc; reset = rst;
        #1;
        modelOutputs();
        checkOutput();
        multPulses += int'(ctrlMult === 1'b1);
        if (ctrlDiv === 1'b1) begin
            divPulses++;
            divGap = cycleNo - lastDivCycle;
            lastDivCycle = cycleNo;
        end
        @(posedge clock);
        modelAdvance();
        cycleNo++;
        @(negedge clock);
    endtask

    function automatic logic [31:0] randInstr();
        int r1 = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 7));
        int r2 = int'($urandom_range(0, 7));
        int r3 = int'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return rType(r1, r2, r3, 0);
            1: return rType(r1, r2, r3, ($urandom_range(0, 1) == 0) ? 6 : 7);
            2: return iType(8, r1, r2, 0);
            3: return iType(7, r1, r2, 4);
            4: return iType(5, r1, r2, 1);
            5: return iType(2, r1, r2, 3);
            6: return iType(6, r1, r2, 3);
            7: return iType(4, r1, 0, 0);
            8: return iType(22, 0, 0, 8);
            default: return iType(1, 0, 0, 16);
        endcase
    endfunction

    logic [31:0] nop, lwR5, lwR6, lwR0, addR5, addR0, swR5R6, mulI, divI;
    int gap;

    initial begin
        nop    = 32'd0;
        lwR5   = iType(8, 5, 2, 0);
        lwR6   = iType(8, 6, 2, 0);
        lwR0   = iType(8, 0, 2, 0);
        addR5  = rType(7, 5, 3, 0);
        addR0  = rType(7, 0, 3, 0);
        swR5R6 = iType(7, 5, 6, 4);
        mulI   = rType(4, 2, 3, 6);
        divI   = rType(4, 2, 3, 7);

        fdIr = nop; dxIr = nop; ctrlTaken = 0; mdRdy = 0; mdException = 0; reset = 0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);

        // Reset outputs, then load-use stall and the r0 exemption.
        applyStimulus(nop, nop, 0, 0, 0, 0);
        applyStimulus(addR5, lwR5, 0, 0, 0, 1);
        applyStimulus(nop, nop, 0, 0, 0, 1);
        checkOne("load_use_stall_count", 64'(stallCount), 64'd1);
        applyStimulus(addR0, lwR0, 0, 0, 0, 1);
        applyStimulus(swR5R6, lwR5, 0, 0, 0, 1);
        applyStimulus(swR5R6, lwR6, 0, 0, 0, 1);
        applyStimulus(nop, nop, 0, 0, 0, 1);
        checkOne("store_exempt_stall_count", 64'(stallCount), 64'd2);

        // Multiply with 17 busy cycles then a result.
        applyStimulus(nop, nop, 0, 0, 0, 0);
        multPulses = 0;
        applyStimulus(nop, mulI, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) applyStimulus(nop, mulI, 0, 0, 0, 1);
        applyStimulus(nop, mulI, 0, 1, 0, 1);
        applyStimulus(nop, nop, 0, 0, 0, 1);
        checkOne("mul_pulses", 64'(multPulses), 64'd1);
        checkOne("mul_stall_count", 64'(stallCount), 64'd17);

        // Back-to-back div; exception on the second result only.
        divPulses = 0;
        applyStimulus(nop, divI, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(nop, divI, 0, 0, 0, 1);
        applyStimulus(nop, divI, 0, 1, 0, 1);
        applyStimulus(nop, divI, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(nop, divI, 0, 0, 0, 1);
        applyStimulus(nop, divI, 0, 1, 1, 1);
        gap = divGap;
        applyStimulus(nop, nop, 0, 0, 0, 1);
        checkOne("div_pulses", 64'(divPulses), 64'd2);
        checkOne("div_gap", 64'(gap), 64'd7);

        // Timeout abort, sticky flag, then reset mid-BUSY with a late result.
        applyStimulus(nop, mulI, 0, 0, 0, 1);
        for (int i = 0; i < MD_TIMEOUT; i++) applyStimulus(nop, mulI, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(nop, nop, 0, 0, 0, 1);
        checkOne("timeout_sticky", 64'(mdTimeout), 64'd1);
        applyStimulus(nop, divI, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(nop, divI, 0, 0, 0, 1);
        applyStimulus(nop, divI, 0, 0, 0, 0);
        applyStimulus(nop, nop, 0, 1, 0, 1);
        applyStimulus(nop, nop, 0, 0, 0, 1);

        // Flush wins over load-use and suppresses a mult/div start.
        applyStimulus(addR5, lwR5, 1, 0, 0, 1);
        multPulses = 0;
        applyStimulus(nop, mulI, 1, 0, 0, 1);
        applyStimulus(addR5, nop, 0, 0, 0, 1);
        checkOne("flush_mul_pulses", 64'(multPulses), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] fd;
            logic [31:0] dx;
            fd = randInstr();
            dx = randInstr();
            applyStimulus(fd, dx, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) != 0));
        end

        // Repeated timeouts drive the narrow counter into saturation.
        applyStimulus(nop, nop, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(nop, mulI, 0, 0, 0, 1);
            for (int i = 0; i < MD_TIMEOUT; i++) applyStimulus(nop, nop, 0, 0, 0, 1);
        end
        applyStimulus(addR5, lwR5, 0, 0, 0, 1);
        applyStimulus(nop, nop, 0, 0, 0, 1);
        checkOne("stall_saturated", 64'(stallCount), 64'(STALL_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
